// File: rtl/race_pkg.sv
// Shared definitions for the drag-race sequencer: state encoding, lamp codes
// and the default finish distance.
package race_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    COUNTDOWN = 2'd1,
    RACING    = 2'd2,
    DONE      = 2'd3
  } race_state_t;

  localparam logic [2:0] LAMPS_OFF = 3'b000;
  localparam logic [2:0] LAMPS_1   = 3'b001;
  localparam logic [2:0] LAMPS_2   = 3'b011;
  localparam logic [2:0] LAMPS_3   = 3'b111;

  localparam logic [31:0] FINISH_DIST_DEFAULT = 32'd4020;

endpackage

// File: rtl/race_timer.sv
// Saturating race timer in 0.1 s ticks; sticks at all-ones and reports sat.
module race_timer #(
  parameter int TIME_W = 16
) (
  input  logic              clk10Hz,
  input  logic              rst,
  input  logic              clear,
  input  logic              enable,
  input  logic              hold,
  output logic [TIME_W-1:0] count,
  output logic              sat
);

  logic [TIME_W-1:0] time_reg;

  always_ff @(posedge clk10Hz or negedge rst) begin
    if (!rst) begin
      time_reg <= '0;
    end else if (clear) begin
      time_reg <= '0;
    end else if (enable && !hold && !sat) begin
      time_reg <= time_reg + 1'b1;
    end
  end

  assign count = time_reg;
  assign sat   = &time_reg;

endmodule

// File: rtl/race_controller.sv
// Race sequencer: countdown lamps, racing enable, finish/timeout detection and
// false-start flagging. Every output comes straight from a register.
module race_controller
  import race_pkg::*;
#(
  parameter logic [31:0] FINISH_DIST = FINISH_DIST_DEFAULT,
  parameter int          STAGE_TICKS = 10,
  parameter int          TIME_W      = 16
) (
  input  logic              clk10Hz,
  input  logic              rst,
  input  logic              start_btn,
  input  logic              throttle,
  input  logic [31:0]       position,
  output logic              reset_status,
  output logic              go,
  output logic [2:0]        lamps,
  output logic              green,
  output logic [TIME_W-1:0] race_time,
  output logic              finished,
  output logic              timeout,
  output logic              false_start,
  output logic [1:0]        state
);

  localparam int CNT_W = $clog2(3 * STAGE_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(3 * STAGE_TICKS - 1);
  localparam logic [CNT_W-1:0] STAGE1   = CNT_W'(STAGE_TICKS);
  localparam logic [CNT_W-1:0] STAGE2   = CNT_W'(2 * STAGE_TICKS);

  race_state_t      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             start_btn_q_reg;
  logic             finished_reg, finished_next;
  logic             timeout_reg, timeout_next;
  logic             false_start_reg, false_start_next;
  logic             reset_status_reg, reset_status_next;
  logic             go_reg, go_next;
  logic             green_reg, green_next;
  logic [2:0]       lamps_reg, lamps_next;

  logic start_edge;
  logic finish_hit;
  logic timer_clear;
  logic timer_sat;

  assign start_edge  = start_btn & ~start_btn_q_reg;
  assign finish_hit  = (position >= FINISH_DIST);
  assign timer_clear = start_edge && ((state_reg == IDLE) || (state_reg == DONE));

  // State register plus the registered copies of every output.
  always_ff @(posedge clk10Hz or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      start_btn_q_reg  <= 1'b0;
      finished_reg     <= 1'b0;
      timeout_reg      <= 1'b0;
      false_start_reg  <= 1'b0;
      reset_status_reg <= 1'b1;
      go_reg           <= 1'b0;
      green_reg        <= 1'b0;
      lamps_reg        <= LAMPS_OFF;
    end else begin
      state_reg        <= state_next;
      cnt_reg          <= cnt_next;
      start_btn_q_reg  <= start_btn;
      finished_reg     <= finished_next;
      timeout_reg      <= timeout_next;
      false_start_reg  <= false_start_next;
      reset_status_reg <= reset_status_next;
      go_reg           <= go_next;
      green_reg        <= green_next;
      lamps_reg        <= lamps_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    cnt_next         = cnt_reg;
    finished_next    = finished_reg;
    timeout_next     = timeout_reg;
    false_start_next = false_start_reg;
    case (state_reg)
      IDLE, DONE: begin
        if (start_edge) begin
          state_next       = COUNTDOWN;
          cnt_next         = '0;
          finished_next    = 1'b0;
          timeout_next     = 1'b0;
          false_start_next = 1'b0;
        end
      end
      COUNTDOWN: begin
        // A false start beats the final countdown tick.
        if (throttle) begin
          state_next       = DONE;
          false_start_next = 1'b1;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = RACING;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RACING: begin
        if (finish_hit) begin
          state_next    = DONE;
          finished_next = 1'b1;
        end else if (timer_sat) begin
          state_next   = DONE;
          timeout_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    reset_status_next = (state_next == IDLE) || (state_next == COUNTDOWN);
    go_next           = (state_next == RACING);
    green_next        = (state_next == RACING);
    lamps_next        = LAMPS_OFF;
    case (state_next)
      COUNTDOWN: begin
        if (cnt_next < STAGE1)      lamps_next = LAMPS_1;
        else if (cnt_next < STAGE2) lamps_next = LAMPS_2;
        else                        lamps_next = LAMPS_3;
      end
      RACING:  lamps_next = LAMPS_3;
      default: lamps_next = LAMPS_OFF;
    endcase
  end

  race_timer #(
    .TIME_W(TIME_W)
  ) u_timer (
    .clk10Hz(clk10Hz),
    .rst    (rst),
    .clear  (timer_clear),
    .enable (state_reg == RACING),
    .hold   (finish_hit),
    .count  (race_time),
    .sat    (timer_sat)
  );

  assign state        = state_reg;
  assign reset_status = reset_status_reg;
  assign go           = go_reg;
  assign green        = green_reg;
  assign lamps        = lamps_reg;
  assign finished     = finished_reg;
  assign timeout      = timeout_reg;
  assign false_start  = false_start_reg;

endmodule

// File: tb/tb_race_controller.sv
// Bench for race_controller: directed vector table, hand-written corner cases
// and randomized traffic checked against a tick-level behavioural model.
module tb_race_controller;

  localparam int TW   = 4;
  localparam int ST   = 10;
  localparam int FIN  = 4020;
  localparam int TMAX = (1 << TW) - 1;

  logic          clk10Hz = 1'b0;
  logic          rst = 1'b0;
  logic          start_btn = 1'b0;
  logic          throttle = 1'b0;
  logic [31:0]   position = '0;
  logic          reset_status, go, green, finished, timeout, false_start;
  logic [2:0]    lamps;
  logic [TW-1:0] race_time;
  logic [1:0]    state;

  int checks = 0;
  int errors = 0;

  always #5 clk10Hz = ~clk10Hz;

  race_controller #(
    .FINISH_DIST(32'd4020),
    .STAGE_TICKS(ST),
    .TIME_W     (TW)
  ) dut (
    .clk10Hz     (clk10Hz),
    .rst         (rst),
    .start_btn   (start_btn),
    .throttle    (throttle),
    .position    (position),
    .reset_status(reset_status),
    .go          (go),
    .lamps       (lamps),
    .green       (green),
    .race_time   (race_time),
    .finished    (finished),
    .timeout     (timeout),
    .false_start (false_start),
    .state       (state)
  );

  // Behavioural model: phase 0 idle, 1 countdown, 2 racing, 3 done.
  int m_phase, m_cd, m_rt;
  bit m_fin, m_to, m_fs, m_btn_q;

  task automatic model_reset();
    m_phase = 0; m_cd = 0; m_rt = 0;
    m_fin = 0; m_to = 0; m_fs = 0; m_btn_q = 0;
  endtask

  task automatic model_step();
    bit edge_seen;
    edge_seen = start_btn && !m_btn_q;
    m_btn_q = start_btn;
    case (m_phase)
      0, 3: if (edge_seen) begin
        m_phase = 1; m_cd = 0; m_rt = 0; m_fin = 0; m_to = 0; m_fs = 0;
      end
      1: begin
        if (throttle) begin m_phase = 3; m_fs = 1; end
        else if (m_cd == 3 * ST - 1) m_phase = 2;
        else m_cd++;
      end
      default: begin
        if (position >= 32'd4020) begin m_phase = 3; m_fin = 1; end
        else if (m_rt == TMAX) begin m_phase = 3; m_to = 1; end
        else m_rt++;
      end
    endcase
  endtask

  function automatic int m_lamps();
    if (m_phase == 1) return (1 << (m_cd / ST + 1)) - 1;
    if (m_phase == 2) return 7;
    return 0;
  endfunction

  task automatic check_vals(input string tag, input int es, input int el, input int ego,
                            input int ers, input int ert, input bit efin, input bit eto,
                            input bit efs);
    bit ok;
    ok = (int'(state) == es) && (int'(lamps) == el) && (int'(go) == ego) &&
         (int'(green) == ego) && (int'(reset_status) == ers) &&
         (int'(race_time) == ert) && (finished == efin) && (timeout == eto) &&
         (false_start == efs);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s t=%0t got st=%0d lamps=%b go=%0d green=%0d rs=%0d rt=%0d fin=%0d to=%0d fs=%0d, want st=%0d lamps=%0d go=%0d rs=%0d rt=%0d fin=%0d to=%0d fs=%0d",
               tag, $time, state, lamps, go, green, reset_status, race_time, finished,
               timeout, false_start, es, el, ego, ers, ert, efin, eto, efs);
    end
  endtask

  task automatic check_model(input string tag);
    check_vals(tag, m_phase, m_lamps(), int'(m_phase == 2), int'(m_phase < 2), m_rt,
               m_fin, m_to, m_fs);
  endtask

  task automatic step();
    @(posedge clk10Hz);
    model_step();
    @(negedge clk10Hz);
    check_model("model");
  endtask

  task automatic run_to_racing();
    start_btn = 1'b1;
    step();
    start_btn = 1'b0;
    repeat (3 * ST) step();
  endtask

  // Pulls rst low between edges, checks the immediate effect, releases on the next negedge.
  task automatic async_reset_pulse();
    #2 rst = 1'b0;
    #1 model_reset();
    check_vals("async_rst", 0, 0, 0, 1, 0, 0, 0, 0);
    @(negedge clk10Hz);
    rst = 1'b1;
    check_model("after_rst");
  endtask

  typedef struct {
    int n; bit btn; bit thr; int pos;
    int st; int lamps; int go; int rs; int rt; bit fin; bit to; bit fs;
  } vec_t;

  function automatic vec_t mk(int n, bit btn, bit thr, int pos, int st, int lmp, int g,
                              int rs, int rt, bit fin, bit to, bit fs);
    vec_t v;
    v.n = n; v.btn = btn; v.thr = thr; v.pos = pos; v.st = st; v.lamps = lmp;
    v.go = g; v.rs = rs; v.rt = rt; v.fin = fin; v.to = to; v.fs = fs;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    //             n btn thr pos   st lmp go rs rt fin to fs
    tbl.push_back(mk(50, 0, 0, 0,    0, 0, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  1, 0, 0,    1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(9,  1, 0, 0,    1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(10, 0, 0, 0,    1, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(10, 0, 0, 0,    1, 7, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  0, 0, 0,    2, 7, 1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1,  0, 0, 100,  2, 7, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(1,  0, 0, 4019, 2, 7, 1, 0, 2, 0, 0, 0));
    tbl.push_back(mk(1,  0, 0, 4020, 3, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(20, 0, 0, 4020, 3, 0, 0, 0, 2, 1, 0, 0));
    tbl.push_back(mk(1,  1, 0, 0,    1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(9,  1, 0, 0,    1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(4,  1, 0, 0,    1, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  1, 1, 0,    3, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(10, 1, 0, 0,    3, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1,  0, 0, 0,    3, 0, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1,  1, 0, 0,    1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(9,  0, 0, 0,    1, 1, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(10, 0, 0, 0,    1, 3, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(10, 0, 0, 0,    1, 7, 0, 1, 0, 0, 0, 0));
    tbl.push_back(mk(1,  0, 0, 0,    2, 7, 1, 0, 0, 0, 0, 0));

    model_reset();
    repeat (3) @(negedge clk10Hz);
    check_vals("reset", 0, 0, 0, 1, 0, 0, 0, 0);
    rst = 1'b1;

    foreach (tbl[r]) begin
      start_btn = tbl[r].btn;
      throttle  = tbl[r].thr;
      position  = 32'(tbl[r].pos);
      for (int k = 0; k < tbl[r].n; k++) begin
        step();
        check_vals($sformatf("tbl_row%0d", r), tbl[r].st, tbl[r].lamps, tbl[r].go,
                   tbl[r].rs, tbl[r].rt, tbl[r].fin, tbl[r].to, tbl[r].fs);
      end
    end
    throttle = 1'b0;
    start_btn = 1'b0;
    position = '0;

    // Timeout: racing with position 0 saturates the timer and ends the run.
    for (int i = 1; i <= TMAX; i++) begin
      step();
      check_vals("timeout_count", 2, 7, 1, 0, i, 0, 0, 0);
    end
    step();
    check_vals("timeout_hit", 3, 0, 0, 0, TMAX, 0, 1, 0);
    repeat (3) step();
    check_vals("timeout_hold", 3, 0, 0, 0, TMAX, 0, 1, 0);

    // Finish and saturation on the same tick: finish takes priority.
    run_to_racing();
    repeat (TMAX) step();
    check_vals("prio_presat", 2, 7, 1, 0, TMAX, 0, 0, 0);
    position = 32'(FIN);
    step();
    check_vals("prio_finish", 3, 0, 0, 0, TMAX, 1, 0, 0);
    position = '0;

    // Asynchronous reset in the middle of a run.
    run_to_racing();
    repeat (3) step();
    async_reset_pulse();
    repeat (5) step();
    check_vals("idle_after_rst", 0, 0, 0, 1, 0, 0, 0, 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 4) == 0) start_btn = ~start_btn;
      throttle = ($urandom_range(0, 29) == 0);
      case ($urandom_range(0, 7))
        0:       position = 32'(4019 + $urandom_range(0, 1));
        1:       position = $urandom;
        default: position = 32'($urandom_range(0, 4019));
      endcase
      if ($urandom_range(0, 299) == 0) async_reset_pulse();
      else step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/race_controller.md
Name: race_controller

Overview:
- Race sequencer for the drag-racing core, clocked on the 10 Hz tick.
- Upstream of position_adder: drives its reset_status input, holding position at 0 until the start. Also supplies the go enable that the drivetrain/speed stage uses to produce d_position.
- Downstream of position_adder: consumes its 32-bit position, detects the finish line, times the run in 0.1 s units and flags false starts.

Parameters:
- FINISH_DIST, 32'd4020: distance in position units at which the run ends.
- STAGE_TICKS, 10: ticks per countdown lamp (1.0 s at 10 Hz).
- TIME_W, 16: width of the race timer.

Ports:
- clk10Hz  in  1  10 Hz system tick clock; all logic is on its rising edge.
- rst  in  1  asynchronous, active-low reset; 0 resets the block immediately.
- start_btn  in  1  start request, already debounced and synchronous, level. The block acts on its rising edge only.
- throttle  in  1  driver throttle pressed, level.
- position  in  32  distance travelled, from position_adder.
- reset_status  out  1  clears position_adder while high.
- go  out  1  drivetrain enable; high only in RACING.
- lamps  out  3  countdown lamps, thermometer code.
- green  out  1  start light; high only in RACING.
- race_time  out  TIME_W  elapsed ticks of the current or last run.
- finished  out  1  run ended at the finish line.
- timeout  out  1  run ended because the timer saturated.
- false_start  out  1  throttle was pressed during the countdown.
- state  out  2  current state, for the display.

Behaviour:
- Reset values (rst=0):
  - state = IDLE, reset_status = 1.
  - go, green, finished, timeout, false_start = 0.
  - lamps = 0, race_time = 0, stage counter = 0, start_btn history register = 0.
- Start edge: start_edge = start_btn & ~start_btn_q. start_btn_q is registered every tick.
- States (2-bit encoding): IDLE=0, COUNTDOWN=1, RACING=2, DONE=3.
- IDLE:
  - reset_status = 1, lamps = 0.
  - start_edge → COUNTDOWN. Clear race_time, finished, timeout and false_start; set cnt = 0.
- COUNTDOWN:
  - reset_status = 1.
  - cnt increments each tick, range 0 .. 3*STAGE_TICKS-1.
  - lamps: 3'b001 while cnt < STAGE_TICKS, 3'b011 while cnt < 2*STAGE_TICKS, otherwise 3'b111.
  - throttle = 1 on any tick → DONE with false_start = 1. This check has priority over the final-tick transition.
  - Tick with cnt = 3*STAGE_TICKS-1 and throttle = 0 → RACING.
  - start_edge is ignored.
- RACING:
  - Outputs: reset_status = 0, go = 1, green = 1, lamps = 3'b111.
  - race_time increments by 1 every tick.
  - position ≥ FINISH_DIST (unsigned compare) → DONE with finished = 1. race_time is not incremented on that tick.
  - race_time = all-ones and position < FINISH_DIST → DONE with timeout = 1, race_time held at all-ones.
  - If both conditions hold on the same tick, finish wins: finished = 1, timeout = 0.
  - Position lags go by one tick; no compensation is applied.
- DONE:
  - Outputs: reset_status = 0, so position stays frozen for the display. go = 0, green = 0, lamps = 0.
  - race_time and the result flags hold.
  - start_edge → COUNTDOWN, clearing the result flags and race_time exactly as IDLE does.
- A held start_btn never retriggers; only a new rising edge does.
- Reset mid-race returns the block to IDLE asynchronously. reset_status is asserted immediately, and position clears on the next tick.
- All outputs are registered, except start_edge, which is used internally only.

Decomposition:
- Package race_pkg: state encoding constants, lamp codes (LAMPS_OFF, LAMPS_1, LAMPS_2, LAMPS_3), and the FINISH_DIST default.
- Sub-module race_timer: clear, enable and hold inputs; TIME_W saturating counter; sat output. The FSM and lamp decode stay in race_controller.

Test Plan:
- Reset then idle: rst low, then high with no start → state = 0, reset_status = 1, lamps = 0, race_time = 0 for 50 ticks.
- Countdown lamps: one start edge → lamps 001 for ticks 1-10, 011 for ticks 11-20, 111 for ticks 21-30. state = 2 and go = 1 on tick 31.
- False start: throttle = 1 at countdown tick 15 → next tick state = 3, false_start = 1, go never asserted, race_time = 0.
- Finish: position stepped to 4019, then 4020 → DONE on the 4020 tick. finished = 1, race_time equals the number of RACING ticks before that tick, and it holds for 20 further ticks.
- Timeout and priority: TIME_W = 4, position held at 0 → timeout = 1 with race_time = 15. Repeat run with position = FINISH_DIST on the saturating tick → finished = 1, timeout = 0.
- Restart and async reset:
  - Held start_btn in DONE → no restart; a new edge → COUNTDOWN with flags cleared.
  - rst pulsed low mid-RACING, between clock edges → IDLE and reset_status = 1 immediately.
